// File: rtl/param_up_down_counter.sv
// param_up_down_counter
//
// Modulo-MODULUS up/down counter. It has a synchronous parallel load, a
// choice of wrap or saturate at the limits, a registered limit-hit pulse and a
// sticky flag for out-of-range loads.
//
// Parameters
//   WIDTH    bit width of count and data_in
//   MODULUS  count range is 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   enable    step enable
//   load      synchronous load request; takes priority over enable
//   up_down   direction: 1 = up, 0 = down
//   sat_mode  behaviour at a limit: 0 = wrap, 1 = saturate
//   clr_err   synchronous clear of load_err; a new load error on the same edge wins
//   data_in   value to load
//   count     registered counter value
//   tc        combinational terminal count for the current direction
//   wrap      registered one-cycle pulse when a step hits a limit
//   load_err  sticky flag, set by a load of data_in >= MODULUS

module param_up_down_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : gen_bad_modulus
    $error("param_up_down_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // All compares and steps are done one bit wider, so MODULUS == 2**WIDTH still fits.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   OneExt = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MaxVal = MaxExt[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] data_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           at_max;
  logic           at_min;
  logic           data_ok;

  assign count_ext = {1'b0, count_q};
  assign data_ext  = {1'b0, data_in};
  assign sum       = count_ext + OneExt;
  assign diff      = count_ext - OneExt;

  // At the top, count+1 reaches MODULUS. At the bottom, count-1 borrows into the extra bit.
  assign at_max  = (sum == ModExt);
  assign at_min  = diff[WIDTH];
  assign data_ok = (data_ext < ModExt);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = err_q;

    if (clr_err) begin
      err_d = 1'b0;
    end

    if (load) begin
      if (data_ok) begin
        count_d = data_in;
      end else begin
        count_d = MaxVal;
        err_d   = 1'b1;
      end
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
          wrap_d = 1'b1;
          if (!sat_mode) begin
            count_d = '0;
          end
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (at_min) begin
          wrap_d = 1'b1;
          if (!sat_mode) begin
            count_d = MaxVal;
          end
        end else begin
          count_d = diff[WIDTH-1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
  // No flop here, so tc follows up_down in the same cycle.
  assign tc       = up_down ? at_max : at_min;

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of count and data_in.
REQ-002 Parameter MODULUS, default 14: count range is 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port enable, input, 1: count step enable.
REQ-006 Port load, input, 1: synchronous parallel load request.
REQ-007 Port up_down, input, 1: direction; 1 = up, 0 = down.
REQ-008 Port sat_mode, input, 1: limit behaviour; 0 = wrap, 1 = saturate.
REQ-009 Port clr_err, input, 1: synchronous clear of load_err.
REQ-010 Port data_in, input, WIDTH: load value.
REQ-011 Port count, output, WIDTH: registered counter value.
REQ-012 Port tc, output, 1: combinational terminal-count indication.
REQ-013 Port wrap, output, 1: registered one-cycle wrap/limit-hit pulse.
REQ-014 Port load_err, output, 1: sticky out-of-range load flag.

Function
REQ-015 Per-edge priority: load, then enable step, then hold.
REQ-016 load=1, data_in < MODULUS: count <= data_in next edge; enable and up_down ignored.
REQ-017 load=1, data_in >= MODULUS: count <= MODULUS-1 and load_err <= 1.
REQ-018 load=0, enable=1, up_down=1, count < MODULUS-1: count <= count+1.
REQ-019 load=0, enable=1, up_down=0, count > 0: count <= count-1.
REQ-020 Up at MODULUS-1, sat_mode=0: count <= 0 and wrap <= 1.
REQ-021 Down at 0, sat_mode=0: count <= MODULUS-1 and wrap <= 1.
REQ-022 Up at MODULUS-1 or down at 0 with sat_mode=1: count holds and wrap <= 1 (limit hit).
REQ-023 wrap is 0 on every edge where REQ-020..022 do not apply, including load edges; consecutive limit events give wrap high on consecutive cycles.
REQ-024 Latency: count, wrap and load_err update exactly one edge after the qualifying inputs.
REQ-025 tc = (up_down & count==MODULUS-1) | (~up_down & count==0), combinational, no flop; changes with up_down in the same cycle.
REQ-026 load=0, enable=0: count holds and wrap <= 0.
REQ-027 clr_err=1 clears load_err next edge, unless the same edge sets it per REQ-017, in which case set wins.
REQ-028 Arithmetic is performed at WIDTH+1 bits; count never holds a value >= MODULUS.
REQ-029 sat_mode and up_down may change on any cycle and take effect on the next edge without extra latency.

Reset
REQ-030 reset low forces count=0, wrap=0 and load_err=0 immediately, independent of clock.
REQ-031 While reset is low, all inputs are ignored and tc reflects count=0 (tc=1 if up_down=0).
REQ-032 The first edge after reset rises behaves per REQ-015..029 with no extra idle cycle.
REQ-033 Reset asserted mid-count or mid-load discards the pending update.

Verification (WIDTH=4, MODULUS=14)
REQ-034 Up wrap: load 12, then enable=1, up_down=1, sat_mode=0 for 3 edges -> count 13, 0, 1; wrap high only in the cycle after 13->0; tc=1 while count=13.
REQ-035 Down saturate: load 1, then enable=1, up_down=0, sat_mode=1 for 3 edges -> count 0, 0, 0; wrap 0, 1, 1.
REQ-036 Bad load: load data_in=15 -> count=13 and load_err=1; clr_err=1 with load data_in=14 on the same edge -> load_err stays 1; a later clr_err alone -> load_err=0.
REQ-037 Priority: load=1, enable=1, data_in=5, up_down=1 -> count=5 (not 6), wrap=0.
REQ-038 Async reset: count=9, reset low between edges -> count=0 before the next edge; after release, one up step -> 1.
REQ-039 Parameter sweep: WIDTH=3, MODULUS=8 up wrap 7->0 with wrap pulse; WIDTH=5, MODULUS=20 down wrap 0->19.
